// File: rtl/m6809_pkg.sv
// ---------------------------------------------------------------------------
// m6809_pkg
// Shared definitions for the 6809 bus peripherals.
//   DATA_W          : data bus width of the register window
//   IRQC_*          : register offsets of the interrupt controller window
//   irqc_wr_t       : a bus write captured during the E-high phase
//   lowest_set_idx  : index of the lowest set bit (bit 0 has priority)
//   valid_mask      : bit mask with the low n bits set
// ---------------------------------------------------------------------------
package m6809_pkg;

    localparam int DATA_W = 8;

    localparam logic [2:0] IRQC_STATUS  = 3'd0;
    localparam logic [2:0] IRQC_MASK    = 3'd1;
    localparam logic [2:0] IRQC_CLEAR   = 3'd2;
    localparam logic [2:0] IRQC_VECTOR  = 3'd3;
    localparam logic [2:0] IRQC_FIRQSEL = 3'd4;

    // A write seen while E is high; it is held until the falling edge of E.
    typedef struct packed {
        logic              valid;
        logic [2:0]        addr;
        logic [DATA_W-1:0] data;
    } irqc_wr_t;

    // The loop runs from the top bit down so that the lowest set bit is the
    // last assignment and therefore wins.
    function automatic logic [2:0] lowest_set_idx(input logic [DATA_W-1:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    // Bits at or above n can never hold state in a controller built with
    // fewer than eight sources.
    function automatic logic [DATA_W-1:0] valid_mask(input int n);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < DATA_W; i++) begin
            m[i] = (i < n);
        end
        return m;
    endfunction

endpackage

// File: rtl/m6809_sync2.sv
// ---------------------------------------------------------------------------
// m6809_sync2
// Two-flop synchroniser for signals that are asynchronous to clk.
// Parameters:
//   WIDTH    number of independent bits synchronised
//   RST_VAL  value both flop stages take while rst_b is low
// Ports:
//   clk    in   1      destination clock
//   rst_b  in   1      synchronous active-low reset
//   d      in   WIDTH  asynchronous input
//   q      out  WIDTH  synchronised output, two clk edges behind d
// ---------------------------------------------------------------------------
module m6809_sync2 #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // First stage may go metastable; the second stage gives it a full
    // cycle to resolve before anything downstream looks at it.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/m6809_irq_ctrl.sv
// ---------------------------------------------------------------------------
// m6809_irq_ctrl
// Interrupt-source controller on the 6809 system bus. Collects up to NSRC
// active-low requests, latches them as pending, masks them and drives the
// CPU's active-low IRQ (and optionally FIRQ). Registers sit in an 8-byte
// window selected by cs_b.
//
// Parameters:
//   NSRC        number of request inputs (1..8)
//   LEVEL_MASK  bit n=1: source n level-sensitive, 0: falling-edge latched
//
// Ports:
//   hsclk    in   1     system clock, all state updates on rising edge
//   rst_b    in   1     synchronous active-low reset
//   eclk     in   1     6809 E clock, asynchronous, synchronised here
//   cs_b     in   1     register window select, active-low
//   rnw      in   1     1=read, 0=write
//   a        in   3     register offset
//   din      in   8     write data
//   dout     out  8     read data (combinational from a)
//   dout_oe  out  1     read-data drive enable for the external buffer
//   src_b    in   NSRC  interrupt requests, active-low, asynchronous
//   irq_b    out  1     IRQ to CPU, active-low
//   firq_b   out  1     FIRQ to CPU, active-low
//
// Register map: 0 STATUS(RO) 1 MASK(RW) 2 CLEAR(WO, W1C) 3 VECTOR(RO)
//               4 FIRQSEL(RW, only with IRQC_FIRQ_ROUTE_EN) 5..7 read 0.
//
// Build option:
//   IRQC_FIRQ_ROUTE_EN  when defined, FIRQSEL routes sources to firq_b;
//                       otherwise firq_b is tied high and register 4 is 0.
// ---------------------------------------------------------------------------
module m6809_irq_ctrl
    import m6809_pkg::*;
#(
    parameter int               NSRC       = 8,
    parameter logic [DATA_W-1:0] LEVEL_MASK = 8'h00
) (
    input  logic              hsclk,
    input  logic              rst_b,
    input  logic              eclk,
    input  logic              cs_b,
    input  logic              rnw,
    input  logic [2:0]        a,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              dout_oe,
    input  logic [NSRC-1:0]   src_b,
    output logic              irq_b,
    output logic              firq_b
);

    localparam logic [DATA_W-1:0] SRC_VALID  = valid_mask(NSRC);
    localparam logic [DATA_W-1:0] LEVEL_BITS = LEVEL_MASK & SRC_VALID;
    localparam logic [DATA_W-1:0] EDGE_BITS  = ~LEVEL_MASK & SRC_VALID;

    logic [DATA_W-1:0] src_b_w;
    logic [DATA_W-1:0] src_s;
    logic [DATA_W-1:0] src_s_d;
    logic [DATA_W-1:0] src_fall;

    logic              eclk_s0;
    logic              eclk_s1;
    logic              eclk_fall;

    irqc_wr_t          wr_q;
    logic              wr_commit;

    logic [DATA_W-1:0] pending;
    logic [DATA_W-1:0] pending_clr;
    logic [DATA_W-1:0] pending_nxt;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] firq_sel;
    logic [DATA_W-1:0] irq_cand;
    logic [DATA_W-1:0] vector;

    // Unused request lanes are parked high so they look like idle sources.
    always_comb begin
        src_b_w = '1;
        for (int i = 0; i < NSRC; i++) begin
            src_b_w[i] = src_b[i];
        end
    end

    m6809_sync2 #(
        .WIDTH   (1),
        .RST_VAL (1'b0)
    ) u_eclk_sync (
        .clk   (hsclk),
        .rst_b (rst_b),
        .d     (eclk),
        .q     (eclk_s0)
    );

    m6809_sync2 #(
        .WIDTH   (DATA_W),
        .RST_VAL ({DATA_W{1'b1}})
    ) u_src_sync (
        .clk   (hsclk),
        .rst_b (rst_b),
        .d     (src_b_w),
        .q     (src_s)
    );

    // One extra stage behind each synchroniser gives the previous sample
    // used for falling-edge detection.
    always_ff @(posedge hsclk) begin
        if (!rst_b) begin
            eclk_s1 <= 1'b0;
            src_s_d <= '1;
        end else begin
            eclk_s1 <= eclk_s0;
            src_s_d <= src_s;
        end
    end

    assign eclk_fall = eclk_s1 & ~eclk_s0;
    assign src_fall  = src_s_d & ~src_s & EDGE_BITS;

    // Address and data are re-captured on every cycle of the write while E
    // is high, so the last values before E falls are the ones committed.
    // The pending flag drops on the E fall, giving one commit per E cycle.
    always_ff @(posedge hsclk) begin
        if (!rst_b) begin
            wr_q <= '0;
        end else if (eclk_s0 && !cs_b && !rnw) begin
            wr_q.valid <= 1'b1;
            wr_q.addr  <= a;
            wr_q.data  <= din;
        end else if (eclk_fall) begin
            wr_q.valid <= 1'b0;
        end
    end

    assign wr_commit = eclk_fall & wr_q.valid;

    // A new edge in the same cycle as a W1C clear takes priority, so no
    // request can be lost to a racing clear. Level sources simply follow
    // their synchronised input and ignore CLEAR.
    always_comb begin
        pending_clr = '0;
        if (wr_commit && (wr_q.addr == IRQC_CLEAR)) begin
            pending_clr = wr_q.data;
        end
        pending_nxt = (((pending & ~pending_clr) | src_fall) & EDGE_BITS)
                    | (~src_s & LEVEL_BITS);
    end

    // Pending and mask registers.
    always_ff @(posedge hsclk) begin
        if (!rst_b) begin
            pending <= '0;
            mask    <= '0;
        end else begin
            pending <= pending_nxt;
            if (wr_commit && (wr_q.addr == IRQC_MASK)) begin
                mask <= wr_q.data & SRC_VALID;
            end
        end
    end

    // IRQ is driven from a register so that the output is glitch-free.
    always_ff @(posedge hsclk) begin
        if (!rst_b) begin
            irq_b <= 1'b1;
        end else begin
            irq_b <= ~(|(pending & mask & ~firq_sel));
        end
    end

`ifdef IRQC_FIRQ_ROUTE_EN
    // FIRQ routing select and the FIRQ output register.
    always_ff @(posedge hsclk) begin
        if (!rst_b) begin
            firq_sel <= '0;
            firq_b   <= 1'b1;
        end else begin
            if (wr_commit && (wr_q.addr == IRQC_FIRQSEL)) begin
                firq_sel <= wr_q.data & SRC_VALID;
            end
            firq_b <= ~(|(pending & mask & firq_sel));
        end
    end
`else
    assign firq_sel = '0;
    assign firq_b   = 1'b1;
`endif

    // VECTOR only reports sources that would pull IRQ low.
    always_comb begin
        irq_cand = pending & mask & ~firq_sel;
        vector   = '0;
        if (|irq_cand) begin
            vector = {1'b1, 4'b0000, lowest_set_idx(irq_cand)};
        end
    end

    // Read mux; CLEAR is write-only and offsets 5..7 read zero.
    always_comb begin
        dout = '0;
        case (a)
            IRQC_STATUS:  dout = pending;
            IRQC_MASK:    dout = mask;
            IRQC_VECTOR:  dout = vector;
            IRQC_FIRQSEL: dout = firq_sel;
            default:      dout = '0;
        endcase
    end

    assign dout_oe = ~cs_b & rnw & eclk_s0;

endmodule

// File: tb/tb_m6809_irq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_m6809_irq_ctrl
// Directed bench for m6809_irq_ctrl. Two instances share the bus: dut is the
// default 8-source edge-only build, dut_l has 4 sources with source 0
// level-sensitive.
// ---------------------------------------------------------------------------
module tb_m6809_irq_ctrl;
    import m6809_pkg::*;

`ifdef IRQC_FIRQ_ROUTE_EN
    localparam bit FIRQ_ON = 1'b1;
`else
    localparam bit FIRQ_ON = 1'b0;
`endif

    logic       hsclk = 1'b0;
    logic       rst_b;
    logic       eclk;
    logic       cs_b;
    logic       rnw;
    logic [2:0] a;
    logic [7:0] din;
    logic [7:0] src_b;

    logic [7:0] dout,   dout_l;
    logic       dout_oe, dout_oe_l;
    logic       irq_b,  irq_b_l;
    logic       firq_b, firq_b_l;

    int n_cmp = 0;
    int n_mis = 0;

    logic [7:0] rd, rd_l;
    logic       oe;

    always #5 hsclk = ~hsclk;

    m6809_irq_ctrl #(.NSRC(8), .LEVEL_MASK(8'h00)) dut (
        .hsclk(hsclk), .rst_b(rst_b), .eclk(eclk), .cs_b(cs_b), .rnw(rnw),
        .a(a), .din(din), .dout(dout), .dout_oe(dout_oe), .src_b(src_b),
        .irq_b(irq_b), .firq_b(firq_b)
    );

    m6809_irq_ctrl #(.NSRC(4), .LEVEL_MASK(8'h01)) dut_l (
        .hsclk(hsclk), .rst_b(rst_b), .eclk(eclk), .cs_b(cs_b), .rnw(rnw),
        .a(a), .din(din), .dout(dout_l), .dout_oe(dout_oe_l), .src_b(src_b[3:0]),
        .irq_b(irq_b_l), .firq_b(firq_b_l)
    );

    // Full E cycle write; returns at the falling clock edge after the commit.
    // race bits pulse src_b low for one clock together with the E fall.
    task automatic bus_write(input logic [2:0] addr, input logic [7:0] data,
                             input logic [7:0] race);
        @(negedge hsclk);
        cs_b = 1'b0; rnw = 1'b0; a = addr; din = data; eclk = 1'b1;
        repeat (4) @(negedge hsclk);
        eclk = 1'b0;
        src_b = src_b & ~race;
        @(negedge hsclk);
        src_b = src_b | race;
        repeat (2) @(negedge hsclk);
        cs_b = 1'b1; rnw = 1'b1;
    endtask

    // Full E cycle read; samples both instances mid E-high.
    task automatic bus_read(input logic [2:0] addr, output logic [7:0] v,
                            output logic v_oe, output logic [7:0] v_l);
        @(negedge hsclk);
        cs_b = 1'b0; rnw = 1'b1; a = addr; eclk = 1'b1;
        repeat (3) @(negedge hsclk);
        v = dout; v_oe = dout_oe; v_l = dout_l;
        eclk = 1'b0; cs_b = 1'b1;
        repeat (3) @(negedge hsclk);
    endtask

    // Pulse request lines low for one clock; returns after the first edge.
    task automatic pulse_src(input logic [7:0] bits);
        @(negedge hsclk);
        src_b = src_b & ~bits;
        @(negedge hsclk);
        src_b = src_b | bits;
    endtask

    task automatic test_reset();
        rst_b = 1'b0; eclk = 1'b0; cs_b = 1'b1; rnw = 1'b1;
        a = IRQC_STATUS; din = 8'h00; src_b = 8'h00;
        repeat (2) @(negedge hsclk);
        n_cmp++; if (irq_b !== 1'b1) begin n_mis++; $display("[TB] FAIL reset_irq_b: got %b want 1", irq_b); end
        n_cmp++; if (firq_b !== 1'b1) begin n_mis++; $display("[TB] FAIL reset_firq_b: got %b want 1", firq_b); end
        n_cmp++; if (dout_oe !== 1'b0) begin n_mis++; $display("[TB] FAIL reset_dout_oe: got %b want 0", dout_oe); end
        n_cmp++; if (dout !== 8'h00) begin n_mis++; $display("[TB] FAIL reset_status: got %h want 00", dout); end
        n_cmp++; if (irq_b_l !== 1'b1) begin n_mis++; $display("[TB] FAIL reset_irq_b_l: got %b want 1", irq_b_l); end
        src_b = 8'hFF;
        @(negedge hsclk);
        rst_b = 1'b1;
        repeat (4) @(negedge hsclk);
        n_cmp++; if (dout !== 8'h00) begin n_mis++; $display("[TB] FAIL post_reset_status: got %h want 00", dout); end
        bus_read(IRQC_MASK, rd, oe, rd_l);
        n_cmp++; if (rd !== 8'h00) begin n_mis++; $display("[TB] FAIL reset_mask: got %h want 00", rd); end
        n_cmp++; if (oe !== 1'b1) begin n_mis++; $display("[TB] FAIL read_dout_oe: got %b want 1", oe); end
    endtask

    task automatic test_reset_mid_write();
        @(negedge hsclk);
        cs_b = 1'b0; rnw = 1'b0; a = IRQC_MASK; din = 8'hAA; eclk = 1'b1;
        repeat (4) @(negedge hsclk);
        rst_b = 1'b0;
        repeat (2) @(negedge hsclk);
        eclk = 1'b0;
        repeat (2) @(negedge hsclk);
        rst_b = 1'b1; cs_b = 1'b1; rnw = 1'b1;
        repeat (3) @(negedge hsclk);
        bus_read(IRQC_STATUS, rd, oe, rd_l);
        bus_read(IRQC_MASK, rd, oe, rd_l);
        n_cmp++; if (rd !== 8'h00) begin n_mis++; $display("[TB] FAIL midwrite_mask: got %h want 00", rd); end
    endtask

    task automatic test_edge_irq();
        bus_write(IRQC_MASK, 8'h05, 8'h00);
        pulse_src(8'h04);
        repeat (2) @(negedge hsclk);
        a = IRQC_STATUS;
        #1;
        n_cmp++; if (irq_b !== 1'b1) begin n_mis++; $display("[TB] FAIL edge_irq_early: got %b want 1", irq_b); end
        n_cmp++; if (dout !== 8'h04) begin n_mis++; $display("[TB] FAIL edge_status: got %h want 04", dout); end
        @(negedge hsclk);
        n_cmp++; if (irq_b !== 1'b0) begin n_mis++; $display("[TB] FAIL edge_irq_low: got %b want 0", irq_b); end
        bus_read(IRQC_VECTOR, rd, oe, rd_l);
        n_cmp++; if (rd !== 8'h82) begin n_mis++; $display("[TB] FAIL edge_vector: got %h want 82", rd); end
        bus_write(IRQC_CLEAR, 8'h04, 8'h00);
        n_cmp++; if (irq_b !== 1'b0) begin n_mis++; $display("[TB] FAIL clear_irq_commit: got %b want 0", irq_b); end
        @(negedge hsclk);
        n_cmp++; if (irq_b !== 1'b1) begin n_mis++; $display("[TB] FAIL clear_irq_high: got %b want 1", irq_b); end
    endtask

    task automatic test_priority();
        bus_write(IRQC_MASK, 8'hFF, 8'h00);
        bus_read(IRQC_MASK, rd, oe, rd_l);
        n_cmp++; if (rd !== 8'hFF) begin n_mis++; $display("[TB] FAIL mask_rw: got %h want ff", rd); end
        n_cmp++; if (rd_l !== 8'h0F) begin n_mis++; $display("[TB] FAIL mask_nsrc4: got %h want 0f", rd_l); end
        bus_write(IRQC_CLEAR, 8'hFF, 8'h00);
        pulse_src(8'h28);
        repeat (4) @(negedge hsclk);
        bus_read(IRQC_VECTOR, rd, oe, rd_l);
        n_cmp++; if (rd !== 8'h83) begin n_mis++; $display("[TB] FAIL prio_vector: got %h want 83", rd); end
        bus_write(IRQC_CLEAR, 8'h08, 8'h00);
        @(negedge hsclk);
        bus_read(IRQC_VECTOR, rd, oe, rd_l);
        n_cmp++; if (rd !== 8'h85) begin n_mis++; $display("[TB] FAIL prio_vector2: got %h want 85", rd); end
        n_cmp++; if (irq_b !== 1'b0) begin n_mis++; $display("[TB] FAIL prio_irq: got %b want 0", irq_b); end
        bus_read(IRQC_CLEAR, rd, oe, rd_l);
        n_cmp++; if (rd !== 8'h00) begin n_mis++; $display("[TB] FAIL clear_reads_zero: got %h want 00", rd); end
        bus_write(IRQC_CLEAR, 8'h20, 8'h00);
        @(negedge hsclk);
        n_cmp++; if (irq_b !== 1'b1) begin n_mis++; $display("[TB] FAIL prio_irq_idle: got %b want 1", irq_b); end
    endtask

    task automatic test_race();
        pulse_src(8'h02);
        repeat (4) @(negedge hsclk);
        n_cmp++; if (irq_b !== 1'b0) begin n_mis++; $display("[TB] FAIL race_setup_irq: got %b want 0", irq_b); end
        bus_write(IRQC_CLEAR, 8'h02, 8'h02);
        a = IRQC_STATUS;
        #1;
        n_cmp++; if (dout !== 8'h02) begin n_mis++; $display("[TB] FAIL race_status: got %h want 02", dout); end
        @(negedge hsclk);
        n_cmp++; if (irq_b !== 1'b0) begin n_mis++; $display("[TB] FAIL race_irq: got %b want 0", irq_b); end
        bus_write(IRQC_CLEAR, 8'h02, 8'h00);
        a = IRQC_STATUS;
        #1;
        n_cmp++; if (dout !== 8'h00) begin n_mis++; $display("[TB] FAIL norace_status: got %h want 00", dout); end
        @(negedge hsclk);
        n_cmp++; if (irq_b !== 1'b1) begin n_mis++; $display("[TB] FAIL norace_irq: got %b want 1", irq_b); end
    endtask

    task automatic test_level();
        bus_write(IRQC_CLEAR, 8'hFF, 8'h00);
        @(negedge hsclk);
        src_b[0] = 1'b0;
        repeat (4) @(negedge hsclk);
        bus_write(IRQC_CLEAR, 8'h01, 8'h00);
        a = IRQC_STATUS;
        #1;
        n_cmp++; if (dout_l !== 8'h01) begin n_mis++; $display("[TB] FAIL level_status: got %h want 01", dout_l); end
        n_cmp++; if (dout !== 8'h00) begin n_mis++; $display("[TB] FAIL edge_cleared: got %h want 00", dout); end
        n_cmp++; if (irq_b_l !== 1'b0) begin n_mis++; $display("[TB] FAIL level_irq: got %b want 0", irq_b_l); end
        @(negedge hsclk);
        src_b[0] = 1'b1;
        repeat (2) @(negedge hsclk);
        n_cmp++; if (dout_l !== 8'h01) begin n_mis++; $display("[TB] FAIL level_hold: got %h want 01", dout_l); end
        @(negedge hsclk);
        n_cmp++; if (dout_l !== 8'h00) begin n_mis++; $display("[TB] FAIL level_release: got %h want 00", dout_l); end
    endtask

    task automatic test_firq_route();
        bus_write(IRQC_CLEAR, 8'hFF, 8'h00);
        bus_write(IRQC_FIRQSEL, 8'h02, 8'h00);
        bus_write(IRQC_MASK, 8'h03, 8'h00);
        bus_read(IRQC_FIRQSEL, rd, oe, rd_l);
        n_cmp++; if (rd !== (FIRQ_ON ? 8'h02 : 8'h00)) begin n_mis++; $display("[TB] FAIL firqsel_read: got %h want %h", rd, (FIRQ_ON ? 8'h02 : 8'h00)); end
        pulse_src(8'h03);
        repeat (4) @(negedge hsclk);
        n_cmp++; if (irq_b !== 1'b0) begin n_mis++; $display("[TB] FAIL route_irq: got %b want 0", irq_b); end
        n_cmp++; if (firq_b !== !FIRQ_ON) begin n_mis++; $display("[TB] FAIL route_firq: got %b want %b", firq_b, !FIRQ_ON); end
        bus_write(IRQC_CLEAR, 8'h01, 8'h00);
        @(negedge hsclk);
        n_cmp++; if (irq_b !== FIRQ_ON) begin n_mis++; $display("[TB] FAIL route_irq_clr: got %b want %b", irq_b, FIRQ_ON); end
        n_cmp++; if (firq_b !== !FIRQ_ON) begin n_mis++; $display("[TB] FAIL route_firq_clr: got %b want %b", firq_b, !FIRQ_ON); end
        bus_read(IRQC_VECTOR, rd, oe, rd_l);
        n_cmp++; if (rd !== (FIRQ_ON ? 8'h00 : 8'h81)) begin n_mis++; $display("[TB] FAIL route_vector: got %h want %h", rd, (FIRQ_ON ? 8'h00 : 8'h81)); end
        bus_read(3'd6, rd, oe, rd_l);
        n_cmp++; if (rd !== 8'h00) begin n_mis++; $display("[TB] FAIL reg6_zero: got %h want 00", rd); end
    endtask

    initial begin
        test_reset();
        test_reset_mid_write();
        test_edge_irq();
        test_priority();
        test_race();
        test_level();
        test_firq_route();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
